// File: rtl/vc_fifo.sv
// Multi-channel flit buffer: NUM_VC independent circular FIFOs sharing one write and one read port.
// Per-channel flags are decoded from registered counts; overflow/underflow are sticky until reset.
module vc_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH_LOG2   = 2,
    parameter int NUM_VC       = 2,
    parameter int VC_LOG2      = 1,
    parameter int AFULL_THRESH = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write,
    input  logic [VC_LOG2-1:0]               wr_vc,
    input  logic [WIDTH-1:0]                 item_in,
    input  logic                             read,
    input  logic [VC_LOG2-1:0]               rd_vc,
    output logic [WIDTH-1:0]                 item_out,
    output logic [NUM_VC-1:0]                full,
    output logic [NUM_VC-1:0]                empty,
    output logic [NUM_VC-1:0]                almost_full,
    output logic [NUM_VC*(DEPTH_LOG2+1)-1:0] count_flat,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem    [NUM_VC][DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr [NUM_VC];
    logic [DEPTH_LOG2-1:0] r_rd_ptr [NUM_VC];
    logic [CW-1:0]         r_count  [NUM_VC];
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_vc_ok;
    logic                  w_rd_vc_ok;
    logic [VC_LOG2-1:0]    w_wr_idx;
    logic [VC_LOG2-1:0]    w_rd_idx;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [NUM_VC-1:0]     w_push_vec;
    logic [NUM_VC-1:0]     w_pop_vec;

    always_comb begin
        full        = '0;
        empty       = '0;
        almost_full = '0;
        count_flat  = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            full[v]                 = (r_count[v] == CW'(DEPTH));
            empty[v]                = (r_count[v] == '0);
            almost_full[v]          = (r_count[v] >= CW'(AFULL_THRESH));
            count_flat[v*CW +: CW]  = r_count[v];
        end
    end

    // Out-of-range channel indices are clamped to 0 for lookups; acceptance still rejects them.
    always_comb begin
        w_wr_vc_ok = (32'(wr_vc) < 32'(NUM_VC));
        w_rd_vc_ok = (32'(rd_vc) < 32'(NUM_VC));
        w_wr_idx   = w_wr_vc_ok ? wr_vc : '0;
        w_rd_idx   = w_rd_vc_ok ? rd_vc : '0;
        w_push_ok  = write && w_wr_vc_ok && !full[w_wr_idx];
        w_pop_ok   = read  && w_rd_vc_ok && !empty[w_rd_idx];
        w_push_vec = '0;
        w_pop_vec  = '0;
        if (w_push_ok) w_push_vec[w_wr_idx] = 1'b1;
        if (w_pop_ok)  w_pop_vec[w_rd_idx]  = 1'b1;
        item_out   = r_mem[w_rd_idx][r_rd_ptr[w_rd_idx]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    r_mem[v][e] <= '0;
                end
            end
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                if (w_push_vec[v]) begin
                    r_mem[v][r_wr_ptr[v]] <= item_in;
                    r_wr_ptr[v]           <= r_wr_ptr[v] + DEPTH_LOG2'(1);
                end
                if (w_pop_vec[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + DEPTH_LOG2'(1);
                end
                case ({w_push_vec[v], w_pop_vec[v]})
                    2'b10:   r_count[v] <= r_count[v] + CW'(1);
                    2'b01:   r_count[v] <= r_count[v] - CW'(1);
                    default: r_count[v] <= r_count[v];
                endcase
            end
            if (write && !w_push_ok) r_overflow  <= 1'b1;
            if (read  && !w_pop_ok)  r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo: expected pops are queued by the stimulus and checked by a negedge monitor.
module tb_vc_fifo;

    localparam int WIDTH = 32;
    localparam int DL2   = 2;
    localparam int NVC   = 2;
    localparam int VL2   = 1;
    localparam int CW    = DL2 + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              write;
    logic [VL2-1:0]    wr_vc;
    logic [WIDTH-1:0]  item_in;
    logic              read;
    logic [VL2-1:0]    rd_vc;
    logic [WIDTH-1:0]  item_out;
    logic [NVC-1:0]    full;
    logic [NVC-1:0]    empty;
    logic [NVC-1:0]    almost_full;
    logic [NVC*CW-1:0] count_flat;
    logic              overflow;
    logic              underflow;

    int                checks = 0;
    int                errors = 0;
    logic              chk_rd = 1'b0;
    logic [WIDTH-1:0]  q_exp [$];

    vc_fifo #(
        .WIDTH       (WIDTH),
        .DEPTH_LOG2  (DL2),
        .NUM_VC      (NVC),
        .VC_LOG2     (VL2),
        .AFULL_THRESH(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .wr_vc      (wr_vc),
        .item_in    (item_in),
        .read       (read),
        .rd_vc      (rd_vc),
        .item_out   (item_out),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count_flat (count_flat),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the stimulus flags an accepted pop, the head flit must match the queue front.
    always @(negedge clk) begin
        if (chk_rd) begin
            checks++;
            if (q_exp.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got 0x%0h with no expected entry queued", item_out);
            end else begin
                logic [WIDTH-1:0] e;
                e = q_exp.pop_front();
                if (item_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", item_out, e);
                end
            end
        end
    end

    // One clock of activity; returns #1 after the committing edge.
    task automatic cyc(input logic w, input logic [VL2-1:0] wv, input logic [WIDTH-1:0] d,
                       input logic r, input logic [VL2-1:0] rv, input logic pop_ok,
                       input logic [WIDTH-1:0] pop_exp);
        write   = w;
        wr_vc   = wv;
        item_in = d;
        read    = r;
        rd_vc   = rv;
        chk_rd  = pop_ok;
        if (pop_ok) q_exp.push_back(pop_exp);
        @(posedge clk);
        #1;
        write  = 1'b0;
        read   = 1'b0;
        chk_rd = 1'b0;
    endtask

    task automatic push(input logic [VL2-1:0] v, input logic [WIDTH-1:0] d);
        cyc(1'b1, v, d, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic pop(input logic [VL2-1:0] v, input logic [WIDTH-1:0] e);
        cyc(1'b0, '0, '0, 1'b1, v, 1'b1, e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; write = 1'b0; wr_vc = '0; item_in = '0; read = 1'b0; rd_vc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'h3);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_afull", 64'(almost_full), 64'h0);
        chk("rst_count", 64'(count_flat), 64'h0);
        chk("rst_item_out", 64'(item_out), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        chk("rst_unf", 64'(underflow), 64'h0);
        reset = 1'b1;

        // Fill vc0, watch almost_full at the third entry and full at the fourth.
        push(1'b0, 32'hA1);
        push(1'b0, 32'hA2);
        chk("afull_at2", 64'(almost_full), 64'h0);
        push(1'b0, 32'hA3);
        chk("afull_at3", 64'(almost_full), 64'h1);
        push(1'b0, 32'hA4);
        chk("full_vc0", 64'(full), 64'h1);
        chk("count_4", 64'(count_flat), 64'h04);
        rd_vc = 1'b0;
        #1;
        chk("head_A1", 64'(item_out), 64'hA1);

        // Write to a full channel alongside a pop: only the pop happens.
        cyc(1'b1, 1'b0, 32'hEE, 1'b1, 1'b0, 1'b1, 32'hA1);
        chk("full_rw_count", 64'(count_flat), 64'h03);
        chk("full_rw_ovf", 64'(overflow), 64'h1);
        chk("full_rw_unf", 64'(underflow), 64'h0);
        chk("full_rw_full", 64'(full), 64'h0);
        pop(1'b0, 32'hA2);
        pop(1'b0, 32'hA3);
        pop(1'b0, 32'hA4);
        chk("drain_empty", 64'(empty), 64'h3);
        chk("drain_unf", 64'(underflow), 64'h0);

        // Empty channel: read refused, simultaneous write accepted.
        cyc(1'b1, 1'b1, 32'hB7, 1'b1, 1'b1, 1'b0, '0);
        chk("empty_rw_count", 64'(count_flat), 64'h08);
        chk("empty_rw_unf", 64'(underflow), 64'h1);
        rd_vc = 1'b1;
        #1;
        chk("head_B7", 64'(item_out), 64'hB7);
        pop(1'b1, 32'hB7);
        chk("b7_drained", 64'(empty), 64'h3);

        // Steady-state pairs on vc0 with count held at 2; pointers wrap several times.
        push(1'b0, 32'hC0);
        push(1'b0, 32'hC1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 32'hC2 + 32'(i), 1'b1, 1'b0, 1'b1, 32'hC0 + 32'(i));
            chk("pair_count", 64'(count_flat), 64'h02);
        end
        chk("vc1_untouched", 64'(empty[1]), 64'h1);
        pop(1'b0, 32'hCA);
        pop(1'b0, 32'hCB);
        chk("pairs_drained", 64'(empty), 64'h3);

        // Independent channels in one cycle: push vc1 while popping vc0.
        push(1'b0, 32'hE0);
        cyc(1'b1, 1'b1, 32'hD0, 1'b1, 1'b0, 1'b1, 32'hE0);
        push(1'b1, 32'hD1);
        push(1'b1, 32'hD2);
        chk("vc1_count3", 64'(count_flat), 64'h18);
        chk("vc1_afull", 64'(almost_full), 64'h2);

        // Asynchronous reset between edges clears everything immediately.
        @(negedge clk);
        reset = 1'b0;
        rd_vc = 1'b1;
        #1;
        chk("async_empty", 64'(empty), 64'h3);
        chk("async_count", 64'(count_flat), 64'h0);
        chk("async_item_out", 64'(item_out), 64'h0);
        chk("async_flags", 64'({overflow, underflow}), 64'h0);
        chk("queue_drained", 64'(q_exp.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
